// File: rtl/rv_alu_arb.sv
// rv_alu_arb: shares one rv_alu between NUM_REQ requesters (grant in IDLE, EXEC, held response in RESP).
// Optional build macro RV_ALU_ARB_FIXED_PRIO_EN: lowest index wins instead of round-robin.
`timescale 1ns/1ps
module rv_alu_arb #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int NUM_REQ    = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_opr_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_opr_b_i,
  input  logic [NUM_REQ*5-1:0]             req_op_sel_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_pc_i,
  output logic [DATA_WIDTH-1:0]            alu_opr_a_o,
  output logic [DATA_WIDTH-1:0]            alu_opr_b_o,
  output logic [4:0]                       alu_op_sel_o,
  output logic [ADDR_WIDTH-1:0]            alu_pc_o,
  input  logic [DATA_WIDTH-1:0]            alu_res_i,
  input  logic                             alu_zero_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  input  logic [NUM_REQ-1:0]               rsp_ready_i,
  output logic [DATA_WIDTH-1:0]            rsp_res_o,
  output logic                             rsp_zero_o,
  output logic                             busy_o
);
  localparam int IDX_W = $clog2(NUM_REQ);

  // Handshakes: a request transfers in the IDLE cycle where req_valid_i[i] && req_ready_o[i];
  // a response transfers in the RESP cycle where rsp_valid_o[owner] && rsp_ready_i[owner].
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        owner;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_found;
  logic [NUM_REQ-1:0]      win_onehot;
  logic [NUM_REQ-1:0]      owner_onehot;
  logic                    owner_rsp_ready;
  logic [DATA_WIDTH-1:0]   sel_a;
  logic [DATA_WIDTH-1:0]   sel_b;
  logic [4:0]              sel_op;
  logic [ADDR_WIDTH-1:0]   sel_pc;

`ifdef RV_ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid_i[k]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       next_ptr;
  logic [2*NUM_REQ-1:0]   rot_valid;
  int                     cand;

  // Doubling the valid vector turns the wrap-around search into a plain scan from bit 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    rot_valid = {req_valid_i, req_valid_i} >> rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && rot_valid[k]) begin
        win_found = 1'b1;
        cand      = int'(rr_ptr) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign next_ptr = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    sel_pc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_a  = req_opr_a_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b  = req_opr_b_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_op = req_op_sel_i[i*5 +: 5];
        sel_pc = req_pc_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign win_onehot      = NUM_REQ'(1) << win_idx;
  assign owner_onehot    = NUM_REQ'(1) << owner;
  assign owner_rsp_ready = |(rsp_ready_i & rsp_valid_o);
  assign req_ready_o     = (state == IDLE && win_found && !rst_i) ? win_onehot : '0;
  assign busy_o          = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      owner        <= '0;
`ifndef RV_ALU_ARB_FIXED_PRIO_EN
      rr_ptr       <= '0;
`endif
      alu_opr_a_o  <= '0;
      alu_opr_b_o  <= '0;
      alu_op_sel_o <= '0;
      alu_pc_o     <= '0;
      rsp_valid_o  <= '0;
      rsp_res_o    <= '0;
      rsp_zero_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            alu_opr_a_o  <= sel_a;
            alu_opr_b_o  <= sel_b;
            alu_op_sel_o <= sel_op;
            alu_pc_o     <= sel_pc;
            owner        <= win_idx;
`ifndef RV_ALU_ARB_FIXED_PRIO_EN
            rr_ptr       <= next_ptr;
`endif
            state        <= EXEC;
          end
        end
        EXEC: begin
          rsp_res_o   <= alu_res_i;
          rsp_zero_o  <= alu_zero_i;
          rsp_valid_o <= owner_onehot;
          state       <= RESP;
        end
        RESP: begin
          // Only the owner's ready bit can match, since rsp_valid_o is one-hot on the owner.
          if (owner_rsp_ready) begin
            rsp_valid_o <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_alu_arb.sv
// Self-checking bench for rv_alu_arb: behavioural ALU, transaction-level arbiter model, directed and random traffic.
`timescale 1ns/1ps
module tb_rv_alu_arb;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int N  = 3;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLT   = 5'd2;
  localparam logic [4:0] OP_SLTU  = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_XOR   = 5'd6;
  localparam logic [4:0] OP_PCADD = 5'd7;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [4:0]    op;
    logic [AW-1:0] pc;
  } op_t;

  typedef struct {
    int  who;
    op_t o;
  } pend_t;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_opr_a;
  logic [N*DW-1:0] req_opr_b;
  logic [N*5-1:0]  req_op_sel;
  logic [N*AW-1:0] req_pc;
  logic [DW-1:0]   alu_opr_a;
  logic [DW-1:0]   alu_opr_b;
  logic [4:0]      alu_op_sel;
  logic [AW-1:0]   alu_pc;
  logic [DW-1:0]   alu_res;
  logic            alu_zero;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_res;
  logic            rsp_zero;
  logic            busy;
  op_t             alu_in;

  always #5 clk = ~clk;

  rv_alu_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_opr_a_i(req_opr_a), .req_opr_b_i(req_opr_b),
    .req_op_sel_i(req_op_sel), .req_pc_i(req_pc),
    .alu_opr_a_o(alu_opr_a), .alu_opr_b_o(alu_opr_b),
    .alu_op_sel_o(alu_op_sel), .alu_pc_o(alu_pc),
    .alu_res_i(alu_res), .alu_zero_i(alu_zero),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_res_o(rsp_res), .rsp_zero_o(rsp_zero),
    .busy_o(busy)
  );

  // Behavioural rv_alu: compare ops report their outcome on the zero/flag line.
  function automatic logic [DW:0] alu_ref(input op_t o);
    logic [DW-1:0] r;
    logic          z;
    case (o.op)
      OP_ADD:   r = o.a + o.b;
      OP_SUB:   r = o.a - o.b;
      OP_SLT:   r = ($signed(o.a) < $signed(o.b)) ? DW'(1) : '0;
      OP_SLTU:  r = (o.a < o.b) ? DW'(1) : '0;
      OP_AND:   r = o.a & o.b;
      OP_OR:    r = o.a | o.b;
      OP_XOR:   r = o.a ^ o.b;
      OP_PCADD: r = o.pc + o.b;
      default:  r = '0;
    endcase
    z = (o.op == OP_SLT || o.op == OP_SLTU) ? r[0] : (r == '0);
    return {z, r};
  endfunction

  assign alu_in = {alu_opr_a, alu_opr_b, alu_op_sel, alu_pc};
  assign {alu_zero, alu_res} = alu_ref(alu_in);

  // ---------------- check / bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic bit_at(input logic [N-1:0] v, input int k);
    logic [N-1:0] s;
    s = v >> k;
    return s[0];
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic op_t mk_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [4:0] op, input logic [AW-1:0] pc);
    op_t o;
    o.a = a; o.b = b; o.op = op; o.pc = pc;
    return o;
  endfunction

  // ---------------- requesters + reference model ----------------
  pend_t         pend_q[$];
  logic [DW:0]   exp_q[$];
  int            obs_grant[$];
  int            obs_cyc[$];
  bit            m_inflight;
  int            m_phase;
  int            m_owner;
  int            m_ptr;
  op_t           m_alu;

  function automatic int head_of(input int i);
    for (int j = 0; j < pend_q.size(); j++)
      if (pend_q[j].who == i) return j;
    return -1;
  endfunction

  function automatic int count_of(input int i);
    int c = 0;
    for (int j = 0; j < pend_q.size(); j++)
      if (pend_q[j].who == i) c++;
    return c;
  endfunction

  function automatic int pick_winner(input logic [N-1:0] v, input int ptr);
`ifdef RV_ALU_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++)
      if (bit_at(v, k)) return k;
    if (ptr < 0) return -1;
`else
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (bit_at(v, idx)) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic push_req(input int who, input op_t o);
    pend_t p;
    p.who = who;
    p.o   = o;
    pend_q.push_back(p);
  endtask

  task automatic model_reset();
    m_inflight = 1'b0;
    m_phase    = 0;
    m_owner    = 0;
    m_ptr      = 0;
    m_alu      = '0;
    exp_q.delete();
  endtask

  task automatic drive_inputs();
    int  j;
    op_t cur;
    req_valid = '0; req_opr_a = '0; req_opr_b = '0; req_op_sel = '0; req_pc = '0;
    for (int i = 0; i < N; i++) begin
      j = head_of(i);
      if (j >= 0) begin
        cur = pend_q[j].o;
        req_valid  |= N'(1) << i;
        req_opr_a  |= (N*DW)'(cur.a) << (i*DW);
        req_opr_b  |= (N*DW)'(cur.b) << (i*DW);
        req_op_sel |= (N*5)'(cur.op) << (i*5);
        req_pc     |= (N*AW)'(cur.pc) << (i*AW);
      end
    end
  endtask

  // Expected outputs for the current cycle, from the transaction model.
  task automatic model_check();
    int w;
    logic [N-1:0] er;
    w  = pick_winner(req_valid, m_ptr);
    er = (!rst && !m_inflight && w >= 0) ? onehot(w) : '0;
    check("req_ready", req_ready, er);
    check("busy", busy, m_inflight);
    check("rsp_valid", rsp_valid, (m_inflight && m_phase == 2) ? onehot(m_owner) : '0);
    if (m_inflight && m_phase == 2 && exp_q.size() > 0) begin
      check("rsp_res", rsp_res, exp_q[0][DW-1:0]);
      check("rsp_zero", rsp_zero, exp_q[0][DW]);
    end
    check("alu_opr_a", alu_opr_a, m_alu.a);
    check("alu_opr_b", alu_opr_b, m_alu.b);
    check("alu_op_sel", alu_op_sel, m_alu.op);
    check("alu_pc", alu_pc, m_alu.pc);
    for (int k = 0; k < N; k++) begin
      if (bit_at(req_ready, k)) begin
        obs_grant.push_back(k);
        obs_cyc.push_back(cyc);
        break;
      end
    end
  endtask

  // A granted op reaches RESP two edges later and stays there until its owner is ready.
  task automatic model_edge();
    int w, j;
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_inflight) begin
      w = pick_winner(req_valid, m_ptr);
      if (w >= 0) begin
        j     = head_of(w);
        m_alu = pend_q[j].o;
        exp_q.push_back(alu_ref(pend_q[j].o));
        pend_q.delete(j);
        m_inflight = 1'b1;
        m_phase    = 1;
        m_owner    = w;
        m_ptr      = (w + 1) % N;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (bit_at(rsp_ready, m_owner)) begin
      m_inflight = 1'b0;
      m_phase    = 0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    drive_inputs();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    pend_q.delete();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int max_cyc, input string tag);
    int n = 0;
    while ((m_inflight || pend_q.size() > 0) && n < max_cyc) begin
      sample();
      advance();
      n++;
    end
    if (m_inflight || pend_q.size() > 0) check({tag, "_timeout"}, 1, 0);
  endtask

  task automatic run_capture(input int max_cyc, output logic [DW-1:0] res, output logic zero);
    int n = 0;
    res  = '1;
    zero = 1'bx;
    while ((m_inflight || pend_q.size() > 0) && n < max_cyc) begin
      sample();
      if (rsp_valid != '0) begin
        res  = rsp_res;
        zero = rsp_zero;
      end
      advance();
      n++;
    end
    if (m_inflight || pend_q.size() > 0) check("capture_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] res;
    logic          zero;
    int            exp_g[$];
    int            w;
    op_t           o;

    rsp_ready = '1;
    model_reset();
    drive_inputs();
    #1 rst = 1'b1;
    #2;
    check("reset_busy", busy, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_res", rsp_res, 0);
    check("reset_alu_a", alu_opr_a, 0);
    check("reset_alu_op", alu_op_sel, 0);
    check("reset_req_ready", req_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic op on requester 0
    do_reset();
    push_req(0, mk_op(64'd5, 64'd7, OP_ADD, 64'h1000));
    sample(); check("basic_ready_T", req_ready, 3'b001); advance();
    sample(); check("basic_op_T1", alu_op_sel, OP_ADD); advance();
    sample(); check("basic_rsp_valid_T2", rsp_valid, 3'b001);
    check("basic_rsp_res_T2", rsp_res, 12); advance();
    sample(); check("basic_busy_T3", busy, 0); advance();

    // Fairness between requesters 0 and 1
    do_reset();
    obs_grant.delete(); obs_cyc.delete();
    push_req(0, mk_op(64'd1, 64'd2, OP_ADD, 64'h0));
    push_req(0, mk_op(64'hf0, 64'h0f, OP_OR, 64'h0));
    push_req(0, mk_op(64'hff, 64'h0f, OP_XOR, 64'h0));
    push_req(0, mk_op(64'hff, 64'h3c, OP_AND, 64'h0));
    push_req(1, mk_op(64'd10, 64'd3, OP_SUB, 64'h0));
    push_req(1, mk_op(64'd2, 64'd5, OP_SLT, 64'h0));
    push_req(1, mk_op(64'd7, 64'd5, OP_SLTU, 64'h0));
    push_req(1, mk_op(64'd0, 64'd4, OP_PCADD, 64'h200));
    rsp_ready = '1;
    drain(60, "fair");
`ifdef RV_ALU_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    check("fair_count", obs_grant.size(), 8);
    for (int k = 0; k < exp_g.size(); k++) begin
      check("fair_grant", (k < obs_grant.size()) ? obs_grant[k] : -1, exp_g[k]);
      if (k > 0 && k < obs_cyc.size())
        check("fair_spacing", obs_cyc[k] - obs_cyc[k-1], 3);
    end

    // Backpressure on requester 1 while requester 0 waits
    do_reset();
    push_req(1, mk_op(64'd9, 64'd4, OP_SUB, 64'h0));
    rsp_ready = 3'b001;
    sample(); check("bp_ready_1", req_ready, 3'b010); advance();
    push_req(0, mk_op(64'd3, 64'd3, OP_ADD, 64'h0));
    sample(); advance();
    for (int k = 0; k < 5; k++) begin
      sample();
      check("bp_hold_res", rsp_res, 5);
      check("bp_hold_valid", rsp_valid, 3'b010);
      check("bp_hold_ready", req_ready, 3'b000);
      advance();
    end
    rsp_ready = 3'b011;
    sample(); advance();
    sample(); check("bp_next_grant", req_ready, 3'b001); advance();
    drain(20, "bp");

    // Compare flag
    do_reset();
    rsp_ready = '1;
    push_req(0, mk_op(64'd3, 64'd9, OP_SLT, 64'h0));
    run_capture(20, res, zero);
    check("slt_lt_res", res, 1);
    check("slt_lt_zero", zero, 1);
    push_req(0, mk_op(64'd9, 64'd3, OP_SLT, 64'h0));
    run_capture(20, res, zero);
    check("slt_ge_res", res, 0);
    check("slt_ge_zero", zero, 0);

    // Reset while in EXEC
    do_reset();
    push_req(0, mk_op(64'h1234, 64'h5678, OP_XOR, 64'h40));
    sample(); advance();
    sample();
    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_a", alu_opr_a, 0);
    check("rst_alu_b", alu_opr_b, 0);
    check("rst_alu_op", alu_op_sel, 0);
    check("rst_alu_pc", alu_pc, 0);
    model_reset();
    pend_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    obs_grant.delete(); obs_cyc.delete();
    push_req(1, mk_op(64'd8, 64'd1, OP_SUB, 64'h0));
    push_req(0, mk_op(64'd8, 64'd1, OP_ADD, 64'h0));
    drain(30, "rst_fresh");
    check("rst_fresh_first", (obs_grant.size() > 0) ? obs_grant[0] : -1, 0);

    // Wrap-around of the round-robin pointer
    do_reset();
    obs_grant.delete(); obs_cyc.delete();
    push_req(2, mk_op(64'd1, 64'd1, OP_ADD, 64'h0));
    drain(20, "wrap_a");
    push_req(0, mk_op(64'd2, 64'd2, OP_ADD, 64'h0));
    push_req(2, mk_op(64'd4, 64'd2, OP_SUB, 64'h0));
    drain(30, "wrap_b");
    exp_g = '{2, 0, 2};
    check("wrap_count", obs_grant.size(), 3);
    for (int k = 0; k < exp_g.size(); k++)
      check("wrap_grant", (k < obs_grant.size()) ? obs_grant[k] : -1, exp_g[k]);

    // Random traffic with random response backpressure
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        w = $urandom_range(0, N-1);
        if (count_of(w) < 2) begin
          case ($urandom_range(0, 3))
            0:       o.a = '0;
            1:       o.a = '1;
            default: o.a = {$urandom, $urandom};
          endcase
          o.b  = ($urandom_range(0, 3) == 0) ? o.a : {$urandom, $urandom};
          o.op = 5'($urandom_range(0, 7));
          o.pc = {$urandom, $urandom};
          push_req(w, o);
        end
      end
      rsp_ready = N'($urandom_range(0, (1 << N) - 1));
      sample();
      advance();
    end
    rsp_ready = '1;
    drain(40, "rand");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/rv_alu_arb.md
Name: rv_alu_arb

Overview:
- Arbiter and sequencer that shares one rv_alu instance between NUM_REQ requesters, e.g. execute-stage integer ops and branch compare / address generation.
- Accepts one request at a time with a valid/ready handshake and registers its operands onto the ALU input ports.
- Captures the combinational ALU result and returns it to the granted requester through a held response handshake.
- Sits between the issue logic and rv_alu in the multi-cycle core variant.

Parameters:
- DATA_WIDTH, 64, operand/result width; matches rv_alu.
- ADDR_WIDTH, 64, PC width; matches rv_alu.
- NUM_REQ, 2, number of requesters, range 2..8.
- IDX_W, derived $clog2(NUM_REQ), grant index width; not overridable.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  one-hot accept pulse.
- req_opr_a_i  in  NUM_REQ*DATA_WIDTH  operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_opr_b_i  in  NUM_REQ*DATA_WIDTH  operand B, same packing.
- req_op_sel_i  in  NUM_REQ*5  op select (instr_op.vh encodings), requester i at [i*5 +: 5].
- req_pc_i  in  NUM_REQ*ADDR_WIDTH  PC, same packing.
- alu_opr_a_o  out  DATA_WIDTH  to rv_alu opr_a_i.
- alu_opr_b_o  out  DATA_WIDTH  to rv_alu opr_b_i.
- alu_op_sel_o  out  5  to rv_alu op_sel_i.
- alu_pc_o  out  ADDR_WIDTH  to rv_alu pc_i.
- alu_res_i  in  DATA_WIDTH  from rv_alu alu_res_o.
- alu_zero_i  in  1  from rv_alu alu_zero_o.
- rsp_valid_o  out  NUM_REQ  one-hot response valid.
- rsp_ready_i  in  NUM_REQ  per-requester response ready.
- rsp_res_o  out  DATA_WIDTH  captured result, shared by all requesters.
- rsp_zero_o  out  1  captured zero/compare flag.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - Asynchronous; all outputs and registers go to 0; state IDLE; round-robin pointer = 0.
  - Reset mid-operation drops the in-flight request and its response silently; requesters must reissue.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid_i is set, select a winner by round-robin: search from the pointer upward, wrapping at NUM_REQ.
  - req_ready_o[winner] = 1 combinationally this cycle only; all other bits stay 0.
  - At the clock edge: latch the winner's operands into the alu_* registers, latch the owner index, advance pointer to (winner+1) mod NUM_REQ, go to EXEC.
  - With no valid request, stay in IDLE; req_ready_o = 0.
- EXEC:
  - alu_* outputs are stable from registers for the full cycle.
  - At the edge: rsp_res_o <= alu_res_i, rsp_zero_o <= alu_zero_i, rsp_valid_o <= one-hot(owner), go to RESP.
- RESP:
  - Hold rsp_valid_o, rsp_res_o and rsp_zero_o stable until rsp_ready_i[owner] = 1.
  - On that handshake: clear rsp_valid_o, go to IDLE.
  - rsp_ready_i bits of non-owners are ignored.
  - No new grant is issued in RESP; the next grant occurs no earlier than the cycle after the response handshake.
- Timing:
  - Latency from accept at cycle T to rsp_valid_o is 2 cycles (rsp_valid_o high at T+2).
  - Maximum throughput is 1 operation per 3 cycles.
- alu_* registers retain the last operation's values after completion; they are not cleared.
- Requesters must hold valid and payload stable until ready. Deasserting valid before grant is allowed and simply removes that requester from arbitration.

Optional Feature:
- Macro RV_ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer register is not implemented.
- Undefined: round-robin as described above.
- Ports and timing are identical in both builds.

Test Plan:
- Basic op: req 0 only, A=5, B=7, op=OP_ADD, rsp_ready_i=1 at cycle T:
  - req_ready_o=2'b01 at T.
  - alu_op_sel_o=OP_ADD at T+1.
  - rsp_valid_o=2'b01 and rsp_res_o=12 at T+2.
  - busy_o=0 at T+3.
- Fairness: both requesters valid continuously with distinct ops, rsp_ready_i=2'b11:
  - Grants alternate 0,1,0,1 every 3 cycles.
  - With RV_ALU_ARB_FIXED_PRIO_EN, every grant goes to 0.
- Backpressure: req 1 op=OP_SUB, A=9, B=4; rsp_ready_i[1]=0 for 5 cycles, req 0 valid throughout:
  - rsp_res_o=5 held stable.
  - req_ready_o stays 0 during the hold.
  - Req 0 is granted in the cycle after the handshake.
- Compare flag: req 0 op=OP_SLT, A=3, B=9 -> rsp_res_o=1, rsp_zero_o=1. Repeat with A=9, B=3 -> 0, 0.
- Reset during EXEC, asserted mid-cycle:
  - busy_o, rsp_valid_o and the alu_* outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a fresh request completes normally with pointer=0.
- Wrap-around with NUM_REQ=3: only req 2 valid, then req 0 and req 2 valid together -> grant 2 first, then 0 (pointer wrapped), then 2.
